// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU controller: opcodes, slice selects
// and the controller state encoding.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_XFER = 3'b110;
  localparam logic [2:0] OP_TEST = 3'b111;

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_NOT = 3'b001;
  localparam logic [2:0] SEL_OR  = 3'b010;
  localparam logic [2:0] SEL_XOR = 3'b011;
  localparam logic [2:0] SEL_ADD = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request, slice and response signals of the serial ALU controller.
// ALU_SERIAL_OVERFLOW_EN adds the rsp_ovf flag.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             slice_a;
  logic             slice_b;
  logic             slice_carry_in;
  logic [2:0]       slice_select;
  logic             slice_out;
  logic             slice_carry_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_neg;
  logic             rsp_carry;
`ifdef ALU_SERIAL_OVERFLOW_EN
  logic             rsp_ovf;
`endif

  // slave: the controller; master: the requester that also hosts the slice
  modport slave (
`ifdef ALU_SERIAL_OVERFLOW_EN
    output rsp_ovf,
`endif
    input  req_valid, req_op, req_a, req_b, slice_out, slice_carry_out, rsp_ready,
    output req_ready, slice_a, slice_b, slice_carry_in, slice_select,
    output rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_carry
  );

  modport master (
`ifdef ALU_SERIAL_OVERFLOW_EN
    input  rsp_ovf,
`endif
    output req_valid, req_op, req_a, req_b, slice_out, slice_carry_out, rsp_ready,
    input  req_ready, slice_a, slice_b, slice_carry_in, slice_select,
    input  rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_carry
  );
endinterface

// File: rtl/alu_op_map.sv
// Opcode decoder: maps a controller opcode onto slice select, B-operand
// conditioning and carry seed.
module alu_op_map
  import alu_pkg::*;
(
  input  logic [2:0] i_op,
  output logic [2:0] o_select,
  output logic       o_b_invert,
  output logic       o_b_zero,
  output logic       o_carry_init,
  output logic       o_is_arith
);

  always_comb begin
    o_select     = SEL_AND;
    o_b_invert   = 1'b0;
    o_b_zero     = 1'b0;
    o_carry_init = 1'b0;
    o_is_arith   = 1'b0;
    case (i_op)
      OP_AND: o_select = SEL_AND;
      OP_NOT: o_select = SEL_NOT;
      OP_OR:  o_select = SEL_OR;
      OP_XOR: o_select = SEL_XOR;
      OP_ADD: begin
        o_select   = SEL_ADD;
        o_is_arith = 1'b1;
      end
      OP_SUB: begin
        // A - B computed as A + ~B + 1
        o_select     = SEL_ADD;
        o_b_invert   = 1'b1;
        o_carry_init = 1'b1;
        o_is_arith   = 1'b1;
      end
      default: begin
        // TRANSFER / TEST: A OR 0 passes A through
        o_select = SEL_OR;
        o_b_zero = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial initiator driving a single 1-bit ALU slice, LSB first.
// Define ALU_SERIAL_OVERFLOW_EN to add the signed-overflow response flag.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_serial_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;

  logic [2:0] w_select;
  logic       w_b_invert;
  logic       w_b_zero;
  logic       w_carry_init;
  logic       w_is_arith;
  logic       w_last;
  logic       w_accept;
  logic       w_carry_in;
  logic       w_b_bit;

  alu_op_map u_op_map (
    .i_op         (r_op),
    .o_select     (w_select),
    .o_b_invert   (w_b_invert),
    .o_b_zero     (w_b_zero),
    .o_carry_init (w_carry_init),
    .o_is_arith   (w_is_arith)
  );

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;
  // The decoder sees only the latched op, so the carry seed is applied on bit 0
  // here instead of being loaded into r_carry at accept time.
  assign w_carry_in = (r_cnt == '0) ? w_carry_init : r_carry;
  assign w_b_bit    = w_b_zero ? 1'b0 : (r_b[r_cnt] ^ w_b_invert);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.req_valid) w_state_next = ST_RUN;
      ST_RUN:  if (w_last)        w_state_next = ST_DONE;
      ST_DONE: if (bus.rsp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready      = rst_n && (r_state == ST_IDLE);
    bus.slice_a        = 1'b0;
    bus.slice_b        = 1'b0;
    bus.slice_carry_in = 1'b0;
    bus.slice_select   = 3'b000;
    bus.rsp_valid      = 1'b0;
    bus.rsp_result     = '0;
    bus.rsp_zero       = 1'b0;
    bus.rsp_neg        = 1'b0;
    bus.rsp_carry      = 1'b0;
    if (r_state == ST_RUN) begin
      bus.slice_a        = r_a[r_cnt];
      bus.slice_b        = w_b_bit;
      bus.slice_carry_in = w_carry_in;
      bus.slice_select   = w_select;
    end
    if (r_state == ST_DONE) begin
      bus.rsp_valid  = 1'b1;
      bus.rsp_result = r_result;
      bus.rsp_zero   = (r_result == '0);
      bus.rsp_neg    = r_result[WIDTH-1];
      bus.rsp_carry  = w_is_arith & r_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 3'b000;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
    end else if (w_accept) begin
      r_op    <= bus.req_op;
      r_a     <= bus.req_a;
      r_b     <= bus.req_b;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_result[r_cnt] <= bus.slice_out;
      r_carry         <= bus.slice_carry_out;
      r_cnt           <= r_cnt + CW'(1);
    end
  end

`ifdef ALU_SERIAL_OVERFLOW_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_ovf <= w_is_arith & (w_carry_in ^ bus.slice_carry_out);
    end
  end

  assign bus.rsp_ovf = (r_state == ST_DONE) ? r_ovf : 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=4) with a behavioural 1-bit slice.
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  alu_serial_ctrl_if #(.WIDTH(4)) bus ();

  alu_serial_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slice
  always_comb begin
    bus.slice_out       = 1'b0;
    bus.slice_carry_out = 1'b0;
    case (bus.slice_select)
      3'b000: bus.slice_out = bus.slice_a & bus.slice_b;
      3'b001: bus.slice_out = ~bus.slice_a;
      3'b010: bus.slice_out = bus.slice_a | bus.slice_b;
      3'b011: bus.slice_out = bus.slice_a ^ bus.slice_b;
      3'b100: begin
        bus.slice_out       = bus.slice_a ^ bus.slice_b ^ bus.slice_carry_in;
        bus.slice_carry_out = (bus.slice_a & bus.slice_b) |
                              (bus.slice_carry_in & (bus.slice_a ^ bus.slice_b));
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Present a request and wait (bounded) until the response is valid.
  task automatic do_req(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        output int lat);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = ~a;
    bus.req_b     = ~b;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs[10];
    int         lat;
    int         nrsp;
    int         idx;
    int         replay;
    logic       acc;
    logic [3:0] got[3];
    int         at[3];
    logic [2:0] bb_op[3];
    logic [3:0] bb_a[3];
    logic [3:0] bb_b[3];
    logic [3:0] bb_exp[3];

    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = 3'b000;
    bus.req_a = 4'h0;
    bus.req_b = 4'h0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_flags", {bus.rsp_zero, bus.rsp_neg, bus.rsp_carry}, 0);
    chk("rst_slice", {bus.slice_a, bus.slice_b, bus.slice_carry_in, bus.slice_select}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_req_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;

    // op, a, b, result, zero, neg, carry, ovf
    vecs[0] = '{OP_ADD,  4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{OP_SUB,  4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{OP_ADD,  4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{OP_NOT,  4'b1010, 4'b0110, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{OP_XOR,  4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{OP_XFER, 4'b1001, 4'b0110, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{OP_AND,  4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{OP_OR,   4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{OP_SUB,  4'b0010, 4'b0101, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{OP_SUB,  4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      $display("vec %0d op=%b a=%b b=%b -> result=%b z=%b n=%b c=%b lat=%0d", i,
               vecs[i].op, vecs[i].a, vecs[i].b, bus.rsp_result, bus.rsp_zero,
               bus.rsp_neg, bus.rsp_carry, lat);
      chk($sformatf("v%0d_latency", i), lat, 5);
      chk($sformatf("v%0d_result", i), bus.rsp_result, vecs[i].res);
      chk($sformatf("v%0d_zero", i), bus.rsp_zero, vecs[i].z);
      chk($sformatf("v%0d_neg", i), bus.rsp_neg, vecs[i].n);
      chk($sformatf("v%0d_carry", i), bus.rsp_carry, vecs[i].c);
`ifdef ALU_SERIAL_OVERFLOW_EN
      chk($sformatf("v%0d_ovf", i), bus.rsp_ovf, vecs[i].v);
`endif
      chk($sformatf("v%0d_req_ready_done", i), bus.req_ready, 0);
      finish_rsp();
      chk($sformatf("v%0d_back_idle", i), {bus.req_ready, bus.rsp_valid}, 2'b10);
    end

    // Backpressure: response held stable, requests ignored in DONE
    do_req(OP_ADD, 4'b0111, 4'b0001, lat);
    for (int k = 0; k < 3; k++) begin
      bus.req_valid = (k == 1);
      bus.req_op = OP_AND;
      bus.req_a = 4'b1111;
      bus.req_b = 4'b1111;
      @(posedge clk);
      #1;
      $display("backpressure cycle %0d valid=%b result=%b req_ready=%b", k,
               bus.rsp_valid, bus.rsp_result, bus.req_ready);
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_result", bus.rsp_result, 4'b1000);
      chk("bp_flags", {bus.rsp_zero, bus.rsp_neg, bus.rsp_carry}, 3'b010);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    finish_rsp();
    chk("bp_release_idle", {bus.req_ready, bus.rsp_valid}, 2'b10);
    @(posedge clk);
    #1;
    chk("bp_no_ghost_req", {bus.req_ready, bus.rsp_valid}, 2'b10);

    // Reset during the second RUN cycle
    bus.req_op = OP_ADD;
    bus.req_a = 4'b1111;
    bus.req_b = 4'b1111;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_run_slice", {bus.slice_a, bus.slice_b, bus.slice_carry_in, bus.slice_select},
        {3'b111, SEL_ADD});
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-run: req_ready=%b slice_sel=%b", bus.req_ready, bus.slice_select);
    chk("arst_slice", {bus.slice_a, bus.slice_b, bus.slice_carry_in, bus.slice_select}, 0);
    chk("arst_req_ready", bus.req_ready, 0);
    chk("arst_rsp", {bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_neg, bus.rsp_carry}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    replay = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) replay++;
    end
    chk("no_replay", replay, 0);
    chk("post_rst_ready", bus.req_ready, 1);
    do_req(OP_ADD, 4'b0010, 4'b0011, lat);
    $display("post-reset ADD 0010+0011 -> result=%b lat=%0d", bus.rsp_result, lat);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_result", bus.rsp_result, 4'b0101);
    finish_rsp();

    // Back-to-back with req_valid held high
    bb_op[0] = OP_ADD; bb_a[0] = 4'b0001; bb_b[0] = 4'b0010; bb_exp[0] = 4'b0011;
    bb_op[1] = OP_XOR; bb_a[1] = 4'b1111; bb_b[1] = 4'b0101; bb_exp[1] = 4'b1010;
    bb_op[2] = OP_SUB; bb_a[2] = 4'b0101; bb_b[2] = 4'b0001; bb_exp[2] = 4'b0100;
    bus.rsp_ready = 1'b1;
    idx = 0;
    nrsp = 0;
    bus.req_op = bb_op[0];
    bus.req_a = bb_a[0];
    bus.req_b = bb_b[0];
    bus.req_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && nrsp < 3; cyc++) begin
      @(negedge clk);
      acc = bus.req_valid && bus.req_ready;
      if (bus.rsp_valid) begin
        got[nrsp] = bus.rsp_result;
        at[nrsp] = cyc;
        $display("b2b rsp %0d at cycle %0d result=%b", nrsp, cyc, bus.rsp_result);
        nrsp++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          bus.req_op = bb_op[idx];
          bus.req_a = bb_a[idx];
          bus.req_b = bb_b[idx];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("b2b_count", nrsp, 3);
    for (int i = 0; i < nrsp; i++)
      chk($sformatf("b2b_result%0d", i), got[i], bb_exp[i]);
    for (int i = 1; i < nrsp; i++)
      chk($sformatf("b2b_interval%0d", i), at[i] - at[i-1], 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
